// File: rtl/mem_io_responder.sv
// Byte-wide memory/IO responder: RAM below the IO window plus UART TX/RX
// byte FIFOs mapped at 0x30000 (data) and 0x30004 (control/status).

module mem_io_fifo #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    wdata,
  output logic [7:0]    head,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level_d
);

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [7:0]  mem_q [2**AW];
  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  logic        do_push, do_pop;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head  = mem_q[rd_q[AW-1:0]];

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_pop  = en && pop && !empty;
  assign do_push = en && push && (!full || do_pop);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (rst || (en && flush)) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + PTR_ONE;
      if (do_pop)  rd_d = rd_q + PTR_ONE;
    end
  end

  assign level_d = wr_d - rd_d;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    wr_q <= wr_d;
    rd_q <= rd_d;
  end

  // NOTE: storage is deliberately not reset; the pointers alone define contents.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem_q[wr_q[AW-1:0]] <= wdata;
  end

endmodule

module mem_io_responder #(
  parameter int RAM_AW  = 17,
  parameter int FIFO_AW = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid
);

  localparam logic [15:0]        REG_DATA  = 16'h0000;
  localparam logic [15:0]        REG_STAT  = 16'h0004;
  localparam logic [FIFO_AW:0]   NEAR_FULL = (FIFO_AW+1)'(2**FIFO_AW - 2);

  logic [7:0]        ram_q [2**RAM_AW];
  logic [RAM_AW-1:0] ram_idx;
  logic [7:0]        mem_dout_q;
  logic              io_full_q;
  logic [7:0]        io_rdata;
  logic              io_sel, io_data_acc, io_stat_acc;
  logic              tx_push, rx_pop, rx_flush;
  logic              tx_empty, rx_empty;
  logic [7:0]        rx_head;
  logic [FIFO_AW:0]  tx_level_d;
  logic              tx_full_unused, rx_full_unused;
  logic [FIFO_AW:0]  rx_level_unused;
  logic              unused_addr;

  assign unused_addr = ^mem_a[31:18];

  assign ram_idx     = mem_a[RAM_AW-1:0];
  assign io_sel      = (mem_a[17:16] == 2'b11);
  assign io_data_acc = io_sel && (mem_a[15:0] == REG_DATA);
  assign io_stat_acc = io_sel && (mem_a[15:0] == REG_STAT);
  assign tx_push     = mem_wr && io_data_acc;
  assign rx_flush    = mem_wr && io_stat_acc;
  assign rx_pop      = !mem_wr && io_data_acc;

  mem_io_fifo #(.AW(FIFO_AW)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .en      (rdy),
    .flush   (1'b0),
    .push    (tx_push),
    .pop     (tx_ready),
    .wdata   (mem_din),
    .head    (tx_data),
    .empty   (tx_empty),
    .full    (tx_full_unused),
    .level_d (tx_level_d)
  );

  mem_io_fifo #(.AW(FIFO_AW)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .en      (rdy),
    .flush   (rx_flush),
    .push    (rx_valid),
    .pop     (rx_pop),
    .wdata   (rx_data),
    .head    (rx_head),
    .empty   (rx_empty),
    .full    (rx_full_unused),
    .level_d (rx_level_unused)
  );

  assign tx_valid = !tx_empty;

  always_comb begin
    io_rdata = 8'h00;
    if (io_data_acc)      io_rdata = rx_empty ? 8'h00 : rx_head;
    else if (io_stat_acc) io_rdata = {6'b0, io_full_q, !rx_empty};
  end

  always_ff @(posedge clk) begin
    if (!rst && rdy && mem_wr && !io_sel) ram_q[ram_idx] <= mem_din;
  end

  // The RAM read samples the array before this edge's write lands: old data wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_dout_q <= 8'h00;
      io_full_q  <= 1'b0;
    end else if (rdy) begin
      if (!mem_wr) mem_dout_q <= io_sel ? io_rdata : ram_q[ram_idx];
      io_full_q <= (tx_level_d >= NEAR_FULL);
    end
  end

  assign mem_dout       = mem_dout_q;
  assign io_buffer_full = io_full_q;

endmodule
